ofs_fim_pcie_ss_sb2ib_pipe: RTL and testbench
=============================================

// Module: ofs_fim_pcie_ss_sb2ib_pipe
//
// PURPOSE
//  Converts a PCIe SS AXI-S stream whose TLP headers arrive on the sideband (tuser hdr + hvalid)
//  into an in-band stream: header in the low HDR_W bits of the first beat, payload shifted up by HDR_W.
//  Width-generic successor of the fixed 512b sb2ib: any DATA_W multiple of HDR_W, registered output,
//  header-only TLPs, tail-flush beat and protocol-error detect. Sits between PCIe SS RX and the FIM TLP mux.
//
// PARAMETERS
//  DATA_W  512  data bus width; DATA_W % HDR_W == 0 and DATA_W >= 2*HDR_W (elaboration $fatal otherwise)
//  HDR_W   256  sideband header width (PCIe SS power-user header)
//  USER_W  1    tuser_vendor width passed through
//
// PORTS
//  clk               in   1          clock
//  rst_n             in   1          synchronous, active-low reset
//  in_tvalid         in   1          input beat valid
//  in_tready         out  1          input beat accepted when in_tvalid & in_tready
//  in_tdata          in   DATA_W     payload only (no header)
//  in_tkeep          in   DATA_W/8   byte enables, contiguous from bit 0
//  in_tlast          in   1          last beat of TLP
//  in_tuser_vendor   in   USER_W     vendor bits, sampled at SOP
//  in_hvalid         in   1          sideband header valid (must be 1 exactly on SOP beats)
//  in_hdr            in   HDR_W      sideband header
//  out_tvalid        out  1          output beat valid (registered)
//  out_tready        in   1          downstream ready
//  out_tdata/tkeep   out  DATA_W, DATA_W/8  in-band stream
//  out_tlast         out  1          last beat of TLP
//  out_tuser_vendor  out  USER_W     SOP-sampled vendor bits, held for whole TLP
//  err_proto         out  1          sticky: hvalid on non-SOP beat, or SOP beat without hvalid
//
// BEHAVIOUR
//  - Reset: out_tvalid=0, out_tlast=0, out_tdata/tkeep=0, err_proto=0, state=SOP, carry regs=0.
//    Reset mid-TLP discards the partial packet; no flush beat is emitted.
//  - Output register: loads when !out_tvalid || out_tready; in_tready = that load condition && state!=FLUSH.
//    Latency 1 clk in->out; full throughput 1 beat/clk except one extra beat per TLP needing FLUSH.
//  - LO=DATA_W-HDR_W. carry = in_tdata[DATA_W-1:LO], ckeep = in_tkeep[DATA_W/8-1:LO/8], captured on every accepted beat.
//  - SOP (accept): out_tdata={in_tdata[LO-1:0],in_hdr}; out_tkeep={in_tkeep[LO/8-1:0],{HDR_W/8{1'b1}}};
//    vendor latched. Header-only TLP = SOP beat with tkeep==0 & tlast -> one beat, tkeep=HDR_W/8 ones, tlast=1.
//  - BODY (accept): out_tdata={in_tdata[LO-1:0],carry}; out_tkeep={in_tkeep[LO/8-1:0],ckeep_prev}.
//  - On accepted in_tlast: if new ckeep==0 -> out_tlast=1, next state SOP; else out_tlast=0, next FLUSH.
//    Not in_tlast: next state BODY.
//  - FLUSH: in_tready=0; on load, out_tdata={0,carry}, out_tkeep={0,ckeep}, out_tlast=1, next SOP.
//  - States: SOP -(accept,!last)->BODY; SOP/BODY -(accept,last,ckeep!=0)->FLUSH;
//    SOP/BODY -(accept,last,ckeep==0)->SOP; FLUSH -(load)->SOP.
//  - Protocol errors set err_proto (cleared only by reset). The beat is still forwarded:
//    an SOP beat without hvalid uses in_hdr as-is; hvalid in BODY is ignored.
//  - Backpressure: output holds all fields stable while out_tvalid & !out_tready.
//
// CONFIGURATION
//  OFS_SB2IB_PIPE_STATS_EN defined: adds outputs stat_pkt_cnt[31:0] (+1 per out TLP with tlast handshake)
//    and stat_stall_cnt[31:0] (+1 per clk with out_tvalid & !out_tready); both reset to 0, wrap at 2^32.
//  Not defined: ports absent, no counters instantiated; datapath identical.
//
// TESTING
//  1. DATA_W=512: hdr=H, 1 beat tkeep=0xFFFFFFFF (32B) tlast -> 1 out beat {payload,H}, tkeep=64'hFFFF_FFFF_FFFF_FFFF (64B), tlast.
//  2. DATA_W=512: 1 beat tkeep all-ones (64B) tlast -> 2 out beats; beat2 tkeep=0x00000000FFFFFFFF, tlast; in_tready=0 on FLUSH clk.
//  3. Header-only: hvalid, tkeep=0, tlast -> 1 beat, tkeep=0xFFFFFFFF, tdata[255:0]=H, tlast, err_proto=0.
//  4. DATA_W=1024, 3-beat TLP, full keep, out_tready toggling 1010 -> 4 out beats, data bit-exact, no loss/dup.
//  5. hvalid=1 on beat 2 of a 2-beat TLP -> err_proto=1 next clk and stays 1; stream still forwarded.
//  6. rst_n low 1 clk mid-TLP (after beat 1) -> out_tvalid=0 next clk; next TLP emitted clean from SOP.

Source files
------------

// File: rtl/ofs_fim_pcie_ss_sb2ib_pipe.sv
// ---------------------------------------------------------------------------
// ofs_fim_pcie_ss_sb2ib_pipe
//
// Converts a PCIe SS AXI-S stream whose TLP headers travel on a sideband
// (in_hdr qualified by in_hvalid on SOP beats) into an in-band stream. The
// header occupies the low HDR_W bits of the first output beat. The payload is
// shifted up by HDR_W, and the top HDR_W bits of every input beat are carried
// into the next output beat. When the last input beat still has bytes in its
// top HDR_W slice, one extra flush beat is emitted to drain the carry.
//
// Parameters
//   DATA_W  data bus width (multiple of HDR_W, at least 2*HDR_W)
//   HDR_W   sideband header width
//   USER_W  tuser_vendor width
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   in_tvalid/in_tready         input handshake
//   in_tdata/in_tkeep/in_tlast  input payload beat (no header)
//   in_tuser_vendor             vendor bits, sampled at SOP
//   in_hvalid/in_hdr            sideband header, valid on SOP beats only
//   out_tvalid/out_tready       registered output handshake
//   out_tdata/out_tkeep/out_tlast  in-band output beat
//   out_tuser_vendor            SOP-sampled vendor bits, held for the TLP
//   err_proto                   sticky protocol error (hvalid misplaced)
//
// Optional build macro OFS_SB2IB_PIPE_STATS_EN adds:
//   stat_pkt_cnt[31:0]          TLPs delivered (tlast handshakes)
//   stat_stall_cnt[31:0]        cycles with out_tvalid & !out_tready
// ---------------------------------------------------------------------------
module ofs_fim_pcie_ss_sb2ib_pipe #(
    parameter int DATA_W = 512,
    parameter int HDR_W  = 256,
    parameter int USER_W = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_tvalid,
    output logic                in_tready,
    input  logic [DATA_W-1:0]   in_tdata,
    input  logic [DATA_W/8-1:0] in_tkeep,
    input  logic                in_tlast,
    input  logic [USER_W-1:0]   in_tuser_vendor,
    input  logic                in_hvalid,
    input  logic [HDR_W-1:0]    in_hdr,
    output logic                out_tvalid,
    input  logic                out_tready,
    output logic [DATA_W-1:0]   out_tdata,
    output logic [DATA_W/8-1:0] out_tkeep,
    output logic                out_tlast,
    output logic [USER_W-1:0]   out_tuser_vendor,
    output logic                err_proto
`ifdef OFS_SB2IB_PIPE_STATS_EN
    ,
    output logic [31:0]         stat_pkt_cnt,
    output logic [31:0]         stat_stall_cnt
`endif
);

    localparam int LO  = DATA_W - HDR_W;
    localparam int KW  = DATA_W / 8;
    localparam int LOB = LO / 8;
    localparam int HB  = HDR_W / 8;

    generate
        if ((DATA_W % HDR_W) != 0 || DATA_W < 2 * HDR_W) begin : g_bad_cfg
            $fatal(1, "ofs_fim_pcie_ss_sb2ib_pipe: DATA_W must be a multiple of HDR_W and >= 2*HDR_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_SOP   = 2'd0,
        ST_BODY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_p0;
    state_t             state_nxt;

    // Carry of the top HDR_W slice of the last accepted beat
    logic [HDR_W-1:0]   carry_p0;
    logic [HB-1:0]      ckeep_p0;

    // Output register
    logic               vld_p1;
    logic [DATA_W-1:0]  tdata_p1;
    logic [KW-1:0]      tkeep_p1;
    logic               tlast_p1;
    logic [USER_W-1:0]  user_p1;
    logic               err_p1;

    logic               vld_nxt;
    logic [DATA_W-1:0]  tdata_nxt;
    logic [KW-1:0]      tkeep_nxt;
    logic               tlast_nxt;
    logic [USER_W-1:0]  user_nxt;
    logic               err_nxt;

    logic               load;
    logic               rdy;
    logic               accept;
    logic               top_empty;
    logic               is_sop;

    // -------- stage p0: handshake, next state and output beat formation ----
    always_comb begin
        load      = !vld_p1 || out_tready;
        rdy       = load && (state_p0 != ST_FLUSH);
        accept    = in_tvalid && rdy;
        is_sop    = (state_p0 == ST_SOP);
        // Empty top slice on the last beat means no carry left to flush.
        top_empty = (in_tkeep[KW-1:LOB] == '0);

        state_nxt = state_p0;
        vld_nxt   = vld_p1;
        tdata_nxt = tdata_p1;
        tkeep_nxt = tkeep_p1;
        tlast_nxt = tlast_p1;
        user_nxt  = user_p1;
        err_nxt   = err_p1;

        case (state_p0)
            ST_SOP, ST_BODY: begin
                if (accept) begin
                    if (!in_tlast) begin
                        state_nxt = ST_BODY;
                    end else if (top_empty) begin
                        state_nxt = ST_SOP;
                    end else begin
                        state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (load) begin
                    state_nxt = ST_SOP;
                end
            end
            default: begin
                state_nxt = ST_SOP;
            end
        endcase

        if (load) begin
            vld_nxt = accept || (state_p0 == ST_FLUSH);
            if (state_p0 == ST_FLUSH) begin
                tdata_nxt = {{LO{1'b0}}, carry_p0};
                tkeep_nxt = {{LOB{1'b0}}, ckeep_p0};
                tlast_nxt = 1'b1;
            end else if (accept) begin
                // SOP beats take the sideband header even without hvalid;
                // the error flag reports that case separately.
                tdata_nxt = {in_tdata[LO-1:0], is_sop ? in_hdr : carry_p0};
                tkeep_nxt = {in_tkeep[LOB-1:0], is_sop ? {HB{1'b1}} : ckeep_p0};
                tlast_nxt = in_tlast && top_empty;
                if (is_sop) begin
                    user_nxt = in_tuser_vendor;
                end
            end
        end

        if (accept && ((is_sop && !in_hvalid) || (!is_sop && in_hvalid))) begin
            err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p0 <= ST_SOP;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_p0 <= '0;
            ckeep_p0 <= '0;
        end else if (accept) begin
            carry_p0 <= in_tdata[DATA_W-1:LO];
            ckeep_p0 <= in_tkeep[KW-1:LOB];
        end
    end

    // -------- stage p1: registered output ----------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            tdata_p1 <= '0;
            tkeep_p1 <= '0;
            tlast_p1 <= 1'b0;
            user_p1  <= '0;
            err_p1   <= 1'b0;
        end else begin
            vld_p1   <= vld_nxt;
            tdata_p1 <= tdata_nxt;
            tkeep_p1 <= tkeep_nxt;
            tlast_p1 <= tlast_nxt;
            user_p1  <= user_nxt;
            err_p1   <= err_nxt;
        end
    end

    assign in_tready        = rdy;
    assign out_tvalid       = vld_p1;
    assign out_tdata        = tdata_p1;
    assign out_tkeep        = tkeep_p1;
    assign out_tlast        = tlast_p1;
    assign out_tuser_vendor = user_p1;
    assign err_proto        = err_p1;

`ifdef OFS_SB2IB_PIPE_STATS_EN
    logic [31:0] pkt_cnt_p1;
    logic [31:0] stall_cnt_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt_p1   <= '0;
            stall_cnt_p1 <= '0;
        end else begin
            if (vld_p1 && out_tready && tlast_p1) begin
                pkt_cnt_p1 <= pkt_cnt_p1 + 32'd1;
            end
            if (vld_p1 && !out_tready) begin
                stall_cnt_p1 <= stall_cnt_p1 + 32'd1;
            end
        end
    end

    assign stat_pkt_cnt   = pkt_cnt_p1;
    assign stat_stall_cnt = stall_cnt_p1;
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_sb2ib_pipe.sv
// ---------------------------------------------------------------------------
// tb_ofs_fim_pcie_ss_sb2ib_pipe
//
// Bench for ofs_fim_pcie_ss_sb2ib_pipe at DATA_W=512, HDR_W=256. The reference
// model treats a TLP as one byte stream: header followed by the payload bytes,
// cut into DATA_W-wide output beats.
// ---------------------------------------------------------------------------
module tb_ofs_fim_pcie_ss_sb2ib_pipe;

    localparam int DATA_W = 512;
    localparam int HDR_W  = 256;
    localparam int USER_W = 1;
    localparam int KW     = DATA_W / 8;
    localparam int HB     = HDR_W / 8;
    localparam int MAXB   = 4;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [KW-1:0]     k;
        logic              l;
        logic [USER_W-1:0] u;
    } beat_t;

    logic               clk;
    logic               rst_n;
    logic               in_tvalid;
    logic               in_tready;
    logic [DATA_W-1:0]  in_tdata;
    logic [KW-1:0]      in_tkeep;
    logic               in_tlast;
    logic [USER_W-1:0]  in_tuser_vendor;
    logic               in_hvalid;
    logic [HDR_W-1:0]   in_hdr;
    logic               out_tvalid;
    logic               out_tready;
    logic [DATA_W-1:0]  out_tdata;
    logic [KW-1:0]      out_tkeep;
    logic               out_tlast;
    logic [USER_W-1:0]  out_tuser_vendor;
    logic               err_proto;
`ifdef OFS_SB2IB_PIPE_STATS_EN
    logic [31:0]        stat_pkt_cnt;
    logic [31:0]        stat_stall_cnt;
`endif

    int                 checks = 0;
    int                 errors = 0;
    int                 rdy_mode = 0;
    logic [DATA_W-1:0]  pay [MAXB];
    beat_t              exp_q[$];
    beat_t              got_q[$];

    ofs_fim_pcie_ss_sb2ib_pipe #(
        .DATA_W(DATA_W),
        .HDR_W (HDR_W),
        .USER_W(USER_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_tvalid       (in_tvalid),
        .in_tready       (in_tready),
        .in_tdata        (in_tdata),
        .in_tkeep        (in_tkeep),
        .in_tlast        (in_tlast),
        .in_tuser_vendor (in_tuser_vendor),
        .in_hvalid       (in_hvalid),
        .in_hdr          (in_hdr),
        .out_tvalid      (out_tvalid),
        .out_tready      (out_tready),
        .out_tdata       (out_tdata),
        .out_tkeep       (out_tkeep),
        .out_tlast       (out_tlast),
        .out_tuser_vendor(out_tuser_vendor),
        .err_proto       (err_proto)
`ifdef OFS_SB2IB_PIPE_STATS_EN
        ,
        .stat_pkt_cnt    (stat_pkt_cnt),
        .stat_stall_cnt  (stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready pattern: 0 = always ready, 1 = toggle, other = random
    initial begin
        out_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_tready = 1'b1;
                1:       out_tready = ~out_tready;
                default: out_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Output capture: a transfer happens at the next rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_tvalid && out_tready) begin
                got_q.push_back({out_tdata, out_tkeep, out_tlast, out_tuser_vendor});
            end
        end
    end

    function automatic logic [KW-1:0] keep_mask(input int n);
        logic [KW-1:0] m;
        for (int i = 0; i < KW; i++) m[i] = (i < n);
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [HDR_W-1:0] rnd_hdr();
        logic [HDR_W-1:0] v;
        for (int i = 0; i < HDR_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model: header bytes then payload bytes, chopped into beats
    task automatic model_tlp(input logic [HDR_W-1:0] hdr, input logic [USER_W-1:0] vnd,
                             input int nb, input int lastb);
        logic [(MAXB+1)*DATA_W-1:0] s;
        int    total;
        int    nout;
        int    rem;
        beat_t b;
        s = '0;
        s[HDR_W-1:0] = hdr;
        for (int i = 0; i < nb; i++) s[HDR_W + i*DATA_W +: DATA_W] = pay[i];
        total = HB + (nb - 1) * KW + lastb;
        nout  = (total + KW - 1) / KW;
        for (int j = 0; j < nout; j++) begin
            rem = total - j * KW;
            b.d = s[j*DATA_W +: DATA_W];
            b.k = keep_mask((rem > KW) ? KW : rem);
            b.l = (j == nout - 1);
            b.u = vnd;
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_tready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout in_tready stuck at %0b, required 1", in_tready);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_tlp(input logic [HDR_W-1:0] hdr, input logic [USER_W-1:0] vnd,
                            input int nb, input int lastb, input logic sop_hv, input int bad_beat);
        for (int i = 0; i < nb; i++) begin
            in_tvalid       = 1'b1;
            in_tdata        = pay[i];
            in_tkeep        = (i == nb - 1) ? keep_mask(lastb) : {KW{1'b1}};
            in_tlast        = (i == nb - 1);
            in_tuser_vendor = vnd;
            in_hvalid       = (i == 0) ? sop_hv : (i == bad_beat);
            in_hdr          = hdr;
            wait_accept();
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        in_hvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (got_q.size() < exp_q.size()) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout beats %0d required %0d", got_q.size(), exp_q.size());
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_tvalid = 1'b0; in_tdata = '0; in_tkeep = '0; in_tlast = 1'b0;
        in_tuser_vendor = '0; in_hvalid = 1'b0; in_hdr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", out_tvalid); end
        checks++; if (out_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b exp 0", out_tlast); end
        checks++; if (out_tdata !== '0) begin errors++; $display("FAIL rst_tdata got %h exp 0", out_tdata); end
        checks++; if (out_tkeep !== '0) begin errors++; $display("FAIL rst_tkeep got %h exp 0", out_tkeep); end
        checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_proto); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_tready !== 1'b1) begin errors++; $display("FAIL rst_tready got %b exp 1", in_tready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_half_beat();
        logic [HDR_W-1:0]  hdr;
        logic [USER_W-1:0] vnd;
        rdy_mode = 0; clear_q();
        hdr = rnd_hdr(); vnd = USER_W'($urandom); pay[0] = rnd_data();
        model_tlp(hdr, vnd, 1, 32);
        send_tlp(hdr, vnd, 1, 32, 1'b1, -1);
        drain();
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL half_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL half_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (got_q.size() < 1 || got_q[0].k !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL half_keep got %h exp ffffffffffffffff", got_q[0].k); end
    endtask

    task automatic test_flush();
        logic [HDR_W-1:0]  hdr;
        logic [USER_W-1:0] vnd;
        rdy_mode = 0; clear_q();
        hdr = rnd_hdr(); vnd = USER_W'($urandom); pay[0] = rnd_data();
        model_tlp(hdr, vnd, 1, 64);
        send_tlp(hdr, vnd, 1, 64, 1'b1, -1);
        @(negedge clk);
        checks++; if (in_tready !== 1'b0) begin errors++; $display("FAIL flush_tready got %b exp 0", in_tready); end
        drain();
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL flush_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL flush_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (got_q.size() < 2 || got_q[1].k !== 64'h0000_0000_FFFF_FFFF || got_q[1].l !== 1'b1) begin
            errors++; $display("FAIL flush_tail keep %h last %b exp 00000000ffffffff 1", got_q[1].k, got_q[1].l);
        end
    endtask

    task automatic test_hdr_only();
        logic [HDR_W-1:0]  hdr;
        logic [USER_W-1:0] vnd;
        rdy_mode = 0; clear_q();
        hdr = rnd_hdr(); vnd = USER_W'($urandom); pay[0] = rnd_data();
        model_tlp(hdr, vnd, 1, 0);
        send_tlp(hdr, vnd, 1, 0, 1'b1, -1);
        drain();
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL hdro_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL hdro_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (got_q.size() < 1 || got_q[0].k !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL hdro_keep got %h exp 00000000ffffffff", got_q[0].k); end
        checks++; if (got_q.size() < 1 || got_q[0].d[HDR_W-1:0] !== hdr) begin errors++; $display("FAIL hdro_hdr got %h exp %h", got_q[0].d[HDR_W-1:0], hdr); end
        checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL hdro_err got %b exp 0", err_proto); end
    endtask

    task automatic test_backpressure();
        logic [HDR_W-1:0]  hdr;
        logic [USER_W-1:0] vnd;
        rdy_mode = 1; clear_q();
        hdr = rnd_hdr(); vnd = USER_W'($urandom);
        for (int i = 0; i < 3; i++) pay[i] = rnd_data();
        model_tlp(hdr, vnd, 3, 64);
        send_tlp(hdr, vnd, 3, 64, 1'b1, -1);
        drain();
        checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL bp_count got %0d exp 4", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        rdy_mode = 0;
    endtask

    task automatic test_err_body();
        logic [HDR_W-1:0]  hdr;
        logic [USER_W-1:0] vnd;
        rdy_mode = 0; clear_q();
        hdr = rnd_hdr(); vnd = USER_W'($urandom);
        for (int i = 0; i < 2; i++) pay[i] = rnd_data();
        checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL errb_pre got %b exp 0", err_proto); end
        model_tlp(hdr, vnd, 2, 48);
        send_tlp(hdr, vnd, 2, 48, 1'b1, 1);
        @(negedge clk);
        checks++; if (err_proto !== 1'b1) begin errors++; $display("FAIL errb_set got %b exp 1", err_proto); end
        drain();
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL errb_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL errb_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (err_proto !== 1'b1) begin errors++; $display("FAIL errb_sticky got %b exp 1", err_proto); end
    endtask

    task automatic test_reset_mid();
        logic [HDR_W-1:0]  hdr;
        logic [USER_W-1:0] vnd;
        rdy_mode = 0; clear_q();
        hdr = rnd_hdr(); vnd = USER_W'($urandom); pay[0] = rnd_data();
        in_tvalid = 1'b1; in_tdata = pay[0]; in_tkeep = {KW{1'b1}}; in_tlast = 1'b0;
        in_tuser_vendor = vnd; in_hvalid = 1'b1; in_hdr = hdr;
        wait_accept();
        rst_n = 1'b0;
        in_tvalid = 1'b0; in_hvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid got %b exp 0", out_tvalid); end
        checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL rmid_err got %b exp 0", err_proto); end
        @(posedge clk);
        #1;
        clear_q();
        hdr = rnd_hdr(); vnd = USER_W'($urandom);
        for (int i = 0; i < 2; i++) pay[i] = rnd_data();
        model_tlp(hdr, vnd, 2, 40);
        send_tlp(hdr, vnd, 2, 40, 1'b1, -1);
        drain();
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rmid_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL rmid_clean_err got %b exp 0", err_proto); end
    endtask

    task automatic test_err_sop();
        logic [HDR_W-1:0]  hdr;
        logic [USER_W-1:0] vnd;
        rdy_mode = 0; clear_q();
        hdr = rnd_hdr(); vnd = USER_W'($urandom);
        for (int i = 0; i < 2; i++) pay[i] = rnd_data();
        model_tlp(hdr, vnd, 2, 20);
        send_tlp(hdr, vnd, 2, 20, 1'b0, -1);
        drain();
        checks++; if (err_proto !== 1'b1) begin errors++; $display("FAIL errs_set got %b exp 1", err_proto); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL errs_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL errs_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [HDR_W-1:0]  hdr;
        logic [USER_W-1:0] vnd;
        int nb;
        int lastb;
        rdy_mode = 2; clear_q();
        for (int t = 0; t < 30; t++) begin
            nb    = $urandom_range(1, MAXB);
            lastb = (nb == 1) ? $urandom_range(0, KW) : $urandom_range(1, KW);
            hdr   = rnd_hdr();
            vnd   = USER_W'($urandom);
            for (int i = 0; i < nb; i++) pay[i] = rnd_data();
            model_tlp(hdr, vnd, nb, lastb);
            send_tlp(hdr, vnd, nb, lastb, 1'b1, -1);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        rdy_mode = 0;
    endtask

    initial begin
        test_reset();
        test_half_beat();
        test_flush();
        test_hdr_only();
        test_backpressure();
        test_err_body();
        test_reset_mid();
        test_err_sop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
